io_timer_responder: RTL
=======================

IO_TIMER_RESPONDER -- requirements
Module: io_timer_responder

Interface
REQ-001 Parameter IO_BASE, default 32'h00007F00, base address of the 256-byte I/O window; address[31:8] SHALL equal IO_BASE[31:8] to select.
REQ-002 Parameter CLK_DIV, default 50000, processor clocks per timer tick, range 2..2^20.
REQ-003 Port clk  input  1  processor clock; all state on rising edge.
REQ-004 Port rst  input  1  synchronous, active-high reset.
REQ-005 Port address  input  32  processor data address.
REQ-006 Port MemRead  input  1  processor read strobe, one cycle per access.
REQ-007 Port MemWrite  input  1  processor write strobe, one cycle per access.
REQ-008 Port io_memory_write  input  32  processor write data.
REQ-009 Port io_memory_read  output  32  registered read data.
REQ-010 Port valid_io_read  output  1  one-cycle pulse qualifying io_memory_read.
REQ-011 Port sw  input  16  asynchronous switch inputs.
REQ-012 Port led  output  16  LED register contents.
REQ-013 Port timer_irq  output  1  level copy of STATUS.match.

Function
REQ-014 Register map (offset = address[7:0]): 0x00 LED RW[15:0]; 0x04 SW RO[15:0]; 0x08 CTRL RW[1:0] (bit0 enable, bit1 autoreload); 0x0C COUNT RW[31:0]; 0x10 CMP RW[31:0]; 0x14 STATUS bit0 match, write-1-to-clear; unused bits read 0.
REQ-015 sw SHALL pass through a two-flop synchronizer; SW reads return the second-stage value.
REQ-016 Write: MemWrite with selected address SHALL update the target register at that edge; writes to SW, unmapped offsets, or unselected addresses SHALL have no effect.
REQ-017 Read: MemRead with selected address in cycle N SHALL drive io_memory_read with the register value as of cycle N and valid_io_read=1 in cycle N+1 only.
REQ-018 Selected unmapped offsets SHALL return 0 with valid_io_read=1; unselected addresses SHALL leave valid_io_read=0 and io_memory_read unchanged.
REQ-019 MemRead and MemWrite together to the same register SHALL return the pre-write value and perform the write.
REQ-020 Back-to-back reads in consecutive cycles SHALL each produce their own valid pulse (throughput 1 read/cycle).
REQ-021 Prescaler: counts 0..CLK_DIV-1 while enable=1; tick asserted one cycle when prescaler equals CLK_DIV-1, then wraps to 0; held at 0 while enable=0.
REQ-022 On tick, COUNT SHALL increment modulo 2^32 (0xFFFFFFFF -> 0).
REQ-023 Match: if COUNT+1 equals CMP on a tick, STATUS.match SHALL set; with autoreload=1 COUNT SHALL load 0 instead of CMP.
REQ-024 Write to COUNT SHALL override a same-cycle tick and SHALL clear the prescaler to 0.
REQ-025 STATUS set and write-1-to-clear in the same cycle: set wins.
REQ-026 Reads SHALL NOT alter any register (STATUS not cleared on read).
REQ-027 led SHALL equal the LED register; timer_irq SHALL equal STATUS.match, both registered.

Reset
REQ-028 rst=1 SHALL clear LED, CTRL, COUNT, CMP, STATUS, prescaler, synchronizer flops, io_memory_read and valid_io_read to 0 at the next edge.
REQ-029 rst asserted mid-access SHALL suppress any pending valid_io_read pulse; a write coincident with rst SHALL be discarded.

Verification
REQ-030 Write 0x0000A5A5 to 0x7F00, read 0x7F00 -> led=0xA5A5 next cycle; read returns 0x0000A5A5 with valid_io_read high exactly one cycle after MemRead.
REQ-031 CLK_DIV=4, CMP=3, CTRL=0x3 -> timer_irq rises 12 cycles after enable; COUNT reads 0 afterward; write 1 to 0x7F14 clears irq.
REQ-032 COUNT=0xFFFFFFFF, CMP=5, enable -> after one tick COUNT=0, match stays 0.
REQ-033 sw=0x1234 applied -> SW read returns 0x1234 no earlier than 2 cycles later; read of 0x7F20 returns 0 valid; read of 0x00002000 gives no valid pulse.
REQ-034 Write COUNT=7 in tick cycle -> COUNT=7, prescaler=0; rst asserted during pending read -> valid_io_read=0, all outputs 0.

Source files
------------

// File: rtl/io_timer_responder.sv
// Memory-mapped I/O responder: LED/switch registers plus a prescaled 32-bit
// timer with compare match, autoreload and a level interrupt.
module io_timer_responder #(
  parameter logic [31:0] IO_BASE = 32'h00007F00,
  parameter int          CLK_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] io_memory_write,
  output logic [31:0] io_memory_read,
  output logic        valid_io_read,
  input  logic [15:0] sw,
  output logic [15:0] led,
  output logic        timer_irq
);

  localparam int            PW       = $clog2(CLK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);

  localparam logic [7:0] OFF_LED    = 8'h00;
  localparam logic [7:0] OFF_SW     = 8'h04;
  localparam logic [7:0] OFF_CTRL   = 8'h08;
  localparam logic [7:0] OFF_COUNT  = 8'h0C;
  localparam logic [7:0] OFF_CMP    = 8'h10;
  localparam logic [7:0] OFF_STATUS = 8'h14;

  logic [15:0]   sw_meta;
  logic [15:0]   sw_sync;
  logic [1:0]    ctrl;
  logic [31:0]   count;
  logic [31:0]   cmp_reg;
  logic [PW-1:0] prescaler;

  logic        sel;
  logic [7:0]  offset;
  logic        wr_en;
  logic        rd_en;
  logic        tick;
  logic [31:0] count_inc;
  logic        count_wr;
  logic        match_set;
  logic        match_clr;
  logic [31:0] read_data;

  assign sel       = (address[31:8] == IO_BASE[31:8]);
  assign offset    = address[7:0];
  assign wr_en     = MemWrite && sel;
  assign rd_en     = MemRead && sel;
  assign tick      = ctrl[0] && (prescaler == PRE_LAST);
  assign count_inc = count + 32'd1;
  assign count_wr  = wr_en && (offset == OFF_COUNT);
  // A software COUNT write cancels the whole tick, including any match it would raise.
  assign match_set = tick && !count_wr && (count_inc == cmp_reg);
  assign match_clr = wr_en && (offset == OFF_STATUS) && io_memory_write[0];

  always_comb begin
    read_data = '0;
    case (offset)
      OFF_LED:    read_data = {16'h0, led};
      OFF_SW:     read_data = {16'h0, sw_sync};
      OFF_CTRL:   read_data = {30'h0, ctrl};
      OFF_COUNT:  read_data = count;
      OFF_CMP:    read_data = cmp_reg;
      OFF_STATUS: read_data = {31'h0, timer_irq};
      default:    read_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_meta        <= '0;
      sw_sync        <= '0;
      led            <= '0;
      ctrl           <= '0;
      count          <= '0;
      cmp_reg        <= '0;
      prescaler      <= '0;
      timer_irq      <= 1'b0;
      io_memory_read <= '0;
      valid_io_read  <= 1'b0;
    end else begin
      sw_meta <= sw;
      sw_sync <= sw_meta;

      valid_io_read <= rd_en;
      if (rd_en)
        io_memory_read <= read_data;

      if (wr_en) begin
        case (offset)
          OFF_LED:  led     <= io_memory_write[15:0];
          OFF_CTRL: ctrl    <= io_memory_write[1:0];
          OFF_CMP:  cmp_reg <= io_memory_write;
          default:  ;
        endcase
      end

      if (count_wr || !ctrl[0] || tick)
        prescaler <= '0;
      else
        prescaler <= prescaler + 1'b1;

      if (count_wr)
        count <= io_memory_write;
      else if (tick)
        count <= (match_set && ctrl[1]) ? 32'd0 : count_inc;

      // Setting has priority over a simultaneous write-1-to-clear.
      if (match_set)
        timer_irq <= 1'b1;
      else if (match_clr)
        timer_irq <= 1'b0;
    end
  end

endmodule
